// File: rtl/engine_sched.sv
// Command sequencer between csb and the compute engine: issues one conv/maxpool/avepool
// operation at a time, waits for the engine's completion edge, and guards against hangs.
module engine_sched #(
  parameter int unsigned TIMEOUT = 1_000_000,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op_type,
  input  logic [31:0]      cmd_op_num,
  output logic [2:0]       op_type,
  output logic [31:0]      op_num,
  output logic             conv_ready,
  output logic             maxpool_ready,
  output logic             avepool_ready,
  input  logic             conv_valid,
  input  logic             maxpool_valid,
  input  logic             avepool_valid,
  output logic             busy,
  output logic             done,
  output logic             err_illegal,
  output logic             err_timeout,
  input  logic             err_clr,
  output logic [CNT_W-1:0] done_cnt
);

  localparam logic [2:0]       OP_CONV    = 3'd2;
  localparam logic [2:0]       OP_MAXPOOL = 3'd4;
  localparam logic [2:0]       OP_AVEPOOL = 3'd5;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [31:0]      WD_LAST    = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  // One-hot engine channel select: bit0 conv, bit1 maxpool, bit2 avepool; zero means illegal.
  function automatic logic [2:0] decode_op(input logic [2:0] code);
    logic [2:0] sel;
    case (code)
      OP_CONV:    sel = 3'b001;
      OP_MAXPOOL: sel = 3'b010;
      OP_AVEPOOL: sel = 3'b100;
      default:    sel = 3'b000;
    endcase
    return sel;
  endfunction

  state_t           state_r;
  logic [2:0]       op_type_r;
  logic [31:0]      op_num_r;
  logic [2:0]       sel_r;
  logic [2:0]       ready_r;
  logic [2:0]       valid_q_r;
  logic             cmd_ready_r;
  logic             done_r;
  logic             err_illegal_r;
  logic             err_timeout_r;
  logic [CNT_W-1:0] done_cnt_r;
  logic [31:0]      wd_cnt_r;

  logic [2:0]       valid_s;
  logic [2:0]       cmd_sel_s;
  logic             accept_s;
  logic             sel_valid_s;
  logic             sel_rise_s;
  logic             wd_expire_s;
  logic             illegal_set_s;
  logic             timeout_set_s;

  // Decode handshake, completion edge of the selected channel, and watchdog expiry.
  always_comb begin
    valid_s       = {avepool_valid, maxpool_valid, conv_valid};
    cmd_sel_s     = decode_op(cmd_op_type);
    accept_s      = cmd_valid & cmd_ready_r;
    sel_valid_s   = |(valid_s & sel_r);
    sel_rise_s    = sel_valid_s & ~(|(valid_q_r & sel_r));
    if (TIMEOUT == 0) begin
      wd_expire_s = 1'b0;
    end else begin
      wd_expire_s = (wd_cnt_r == WD_LAST);
    end
    illegal_set_s = (state_r == S_IDLE) & accept_s & (cmd_sel_s == 3'b000);
    timeout_set_s = (state_r == S_RUN) & ~sel_rise_s & wd_expire_s;
  end

  // Sequencer state, engine interface, counters and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= S_IDLE;
      op_type_r     <= 3'd0;
      op_num_r      <= 32'd0;
      sel_r         <= 3'b000;
      ready_r       <= 3'b000;
      valid_q_r     <= 3'b000;
      cmd_ready_r   <= 1'b0;
      done_r        <= 1'b0;
      err_illegal_r <= 1'b0;
      err_timeout_r <= 1'b0;
      done_cnt_r    <= {CNT_W{1'b0}};
      wd_cnt_r      <= 32'd0;
    end else begin
      valid_q_r <= valid_s;
      done_r    <= 1'b0;

      // Setting events win over a simultaneous clear.
      if (illegal_set_s) begin
        err_illegal_r <= 1'b1;
      end else if (err_clr) begin
        err_illegal_r <= 1'b0;
      end else begin
        err_illegal_r <= err_illegal_r;
      end

      if (timeout_set_s) begin
        err_timeout_r <= 1'b1;
      end else if (err_clr) begin
        err_timeout_r <= 1'b0;
      end else begin
        err_timeout_r <= err_timeout_r;
      end

      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            if (cmd_sel_s == 3'b000) begin
              cmd_ready_r <= 1'b1;
            end else if (cmd_op_num == 32'd0) begin
              // Nothing for the engine to do: retire immediately without a start strobe.
              cmd_ready_r <= 1'b1;
              done_r      <= 1'b1;
              done_cnt_r  <= done_cnt_r + CNT_ONE;
            end else begin
              cmd_ready_r <= 1'b0;
              op_type_r   <= cmd_op_type;
              op_num_r    <= cmd_op_num;
              sel_r       <= cmd_sel_s;
              state_r     <= S_ISSUE;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        S_ISSUE: begin
          ready_r  <= sel_r;
          wd_cnt_r <= 32'd0;
          state_r  <= S_RUN;
        end
        S_RUN: begin
          if (sel_rise_s) begin
            ready_r    <= 3'b000;
            done_r     <= 1'b1;
            done_cnt_r <= done_cnt_r + CNT_ONE;
            state_r    <= S_DRAIN;
          end else if (wd_expire_s) begin
            ready_r <= 3'b000;
            state_r <= S_DRAIN;
          end else begin
            wd_cnt_r <= wd_cnt_r + 32'd1;
          end
        end
        S_DRAIN: begin
          if (!sel_valid_s) begin
            cmd_ready_r <= 1'b1;
            state_r     <= S_IDLE;
          end else begin
            cmd_ready_r <= 1'b0;
          end
        end
        default: begin
          ready_r     <= 3'b000;
          cmd_ready_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign cmd_ready     = cmd_ready_r;
  assign op_type       = op_type_r;
  assign op_num        = op_num_r;
  assign conv_ready    = ready_r[0];
  assign maxpool_ready = ready_r[1];
  assign avepool_ready = ready_r[2];
  assign busy          = (state_r != S_IDLE);
  assign done          = done_r;
  assign err_illegal   = err_illegal_r;
  assign err_timeout   = err_timeout_r;
  assign done_cnt      = done_cnt_r;

endmodule

// File: tb/tb_engine_sched.sv
// Directed bench for engine_sched: stimulus pushes expected starts/completions into queues,
// a negedge monitor pops and compares them; a second instance exercises the watchdog.
module tb_engine_sched;

  logic        clk = 1'b0;
  logic        rst, cmd_valid, cmd_valid_w, err_clr;
  logic [2:0]  cmd_op_type;
  logic [31:0] cmd_op_num;
  logic        conv_valid, maxpool_valid, avepool_valid;

  logic        cmd_ready, conv_ready, maxpool_ready, avepool_ready;
  logic        busy, done, err_illegal, err_timeout;
  logic [2:0]  op_type;
  logic [31:0] op_num;
  logic [15:0] done_cnt;

  logic        w_cmd_ready, w_conv_ready, w_maxpool_ready, w_avepool_ready;
  logic        w_busy, w_done, w_err_illegal, w_err_timeout;
  logic [2:0]  w_op_type;
  logic [31:0] w_op_num;
  logic [15:0] w_done_cnt;

  always #5 clk = ~clk;

  engine_sched #(.TIMEOUT(1000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op_type(cmd_op_type), .cmd_op_num(cmd_op_num), .op_type(op_type), .op_num(op_num),
    .conv_ready(conv_ready), .maxpool_ready(maxpool_ready), .avepool_ready(avepool_ready),
    .conv_valid(conv_valid), .maxpool_valid(maxpool_valid), .avepool_valid(avepool_valid),
    .busy(busy), .done(done), .err_illegal(err_illegal), .err_timeout(err_timeout),
    .err_clr(err_clr), .done_cnt(done_cnt)
  );

  engine_sched #(.TIMEOUT(16), .CNT_W(16)) dut_w (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid_w), .cmd_ready(w_cmd_ready),
    .cmd_op_type(cmd_op_type), .cmd_op_num(cmd_op_num), .op_type(w_op_type), .op_num(w_op_num),
    .conv_ready(w_conv_ready), .maxpool_ready(w_maxpool_ready), .avepool_ready(w_avepool_ready),
    .conv_valid(conv_valid), .maxpool_valid(maxpool_valid), .avepool_valid(avepool_valid),
    .busy(w_busy), .done(w_done), .err_illegal(w_err_illegal), .err_timeout(w_err_timeout),
    .err_clr(err_clr), .done_cnt(w_done_cnt)
  );

  typedef struct {
    logic [2:0]  rdy;
    logic [2:0]  t;
    logic [31:0] n;
  } start_t;

  start_t      start_q[$];
  logic [15:0] done_q[$];
  logic [15:0] exp_cnt = 16'd0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] rdy, input logic [2:0] t, input logic [31:0] n,
                          input bit completes);
    start_t e;
    e.rdy = rdy;
    e.t   = t;
    e.n   = n;
    if (rdy != 3'b000) start_q.push_back(e);
    if (completes) begin
      exp_cnt = exp_cnt + 16'd1;
      done_q.push_back(exp_cnt);
    end
  endtask

  task automatic issue(input logic [2:0] t, input logic [31:0] n);
    cmd_op_type = t;
    cmd_op_num  = n;
    cmd_valid   = 1'b1;
  endtask

  task automatic wait_ready(input logic [2:0] mask);
    int i;
    i = 0;
    while ((({avepool_ready, maxpool_ready, conv_ready} & mask) == 3'b000) && (i < 50)) begin
      @(negedge clk);
      i++;
    end
    if (i >= 50) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_ready: mask %b not raised within 50 cycles", mask);
    end
  endtask

  // Scoreboard monitor: every start strobe and every done pulse must match a queued expectation.
  logic [2:0] prev_rdy  = 3'b000;
  logic       prev_done = 1'b0;
  always @(negedge clk) begin
    logic [2:0]  rdy;
    start_t      e;
    logic [15:0] c;
    rdy = {avepool_ready, maxpool_ready, conv_ready};
    if ((rdy != 3'b000) && (prev_rdy == 3'b000)) begin
      if (start_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected start: ready=%b with nothing expected", rdy);
      end else begin
        e = start_q.pop_front();
        check("start ready onehot", {29'd0, rdy}, {29'd0, e.rdy});
        check("start op_type", {29'd0, op_type}, {29'd0, e.t});
        check("start op_num", op_num, e.n);
      end
    end
    if (done) begin
      if (done_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected done: done_cnt=%0d with nothing expected", done_cnt);
      end else begin
        c = done_q.pop_front();
        check("done_cnt at done", {16'd0, done_cnt}, {16'd0, c});
        check("done single cycle", {31'd0, prev_done}, 32'd0);
      end
    end
    prev_rdy  = rdy;
    prev_done = done;
  end

  initial begin
    #100000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    int i;
    bit ok;
    bit any_done;
    rst = 1'b0; cmd_valid = 1'b0; cmd_valid_w = 1'b0; err_clr = 1'b0;
    cmd_op_type = 3'd0; cmd_op_num = 32'd0;
    conv_valid = 1'b0; maxpool_valid = 1'b0; avepool_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("reset flags", {24'd0, cmd_ready, busy, done, err_illegal, err_timeout,
                          conv_ready, maxpool_ready, avepool_ready}, 32'd0);
    check("reset op_type", {29'd0, op_type}, 32'd0);
    check("reset op_num", op_num, 32'd0);
    check("reset done_cnt", {16'd0, done_cnt}, 32'd0);
    check("reset wd cmd_ready", {31'd0, w_cmd_ready}, 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("cmd_ready after reset", {30'd0, cmd_ready, busy}, 32'b10);

    // conv {2,9}, engine completes 40 cycles after start
    push_exp(3'b001, 3'd2, 32'd9, 1'b1);
    issue(3'd2, 32'd9);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("conv issue cycle", {27'd0, cmd_ready, busy, conv_ready, maxpool_ready, avepool_ready},
          32'b01000);
    check("conv issue op_num", op_num, 32'd9);
    @(negedge clk);
    cnt = 0;
    ok  = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cnt = cnt + int'(conv_ready);
      if (maxpool_ready || avepool_ready || done) ok = 1'b0;
      @(negedge clk);
    end
    check("conv ready cycles", cnt, 32'd40);
    check("conv others quiet", {31'd0, ok}, 32'd1);
    check("conv ready before valid", {31'd0, conv_ready}, 32'd1);
    conv_valid = 1'b1;
    @(negedge clk);
    check("conv completion", {29'd0, conv_ready, done, busy}, 32'b011);
    @(negedge clk);
    check("conv drain", {29'd0, done, busy, cmd_ready}, 32'b010);
    conv_valid = 1'b0;
    @(negedge clk);
    check("conv back idle", {30'd0, busy, cmd_ready}, 32'b01);
    check("conv done_cnt", {16'd0, done_cnt}, 32'd1);

    // back-to-back maxpool {4,9} then avepool {5,169} with cmd_valid held
    push_exp(3'b010, 3'd4, 32'd9, 1'b1);
    issue(3'd4, 32'd9);
    @(negedge clk);
    cmd_op_type = 3'd5;
    cmd_op_num  = 32'd169;
    push_exp(3'b100, 3'd5, 32'd169, 1'b1);
    wait_ready(3'b010);
    ok = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (op_type != 3'd4 || op_num != 32'd9 || cmd_ready) ok = 1'b0;
      @(negedge clk);
    end
    maxpool_valid = 1'b1;
    @(negedge clk);
    check("maxpool completion", {30'd0, maxpool_ready, done}, 32'b01);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (op_type != 3'd4 || cmd_ready || !busy) ok = 1'b0;
    end
    check("maxpool held through drain", {31'd0, ok}, 32'd1);
    maxpool_valid = 1'b0;
    @(negedge clk);
    check("drain exit", {29'd0, cmd_ready, busy, op_type == 3'd4}, 32'b101);
    @(negedge clk);
    check("second accept", {31'd0, cmd_ready}, 32'd0);
    check("second op_type", {29'd0, op_type}, 32'd5);
    check("second op_num", op_num, 32'd169);
    cmd_valid = 1'b0;
    wait_ready(3'b100);
    repeat (3) @(negedge clk);
    avepool_valid = 1'b1;
    @(negedge clk);
    check("avepool completion", {29'd0, avepool_ready, done, op_type == 3'd5}, 32'b011);
    avepool_valid = 1'b0;
    @(negedge clk);
    check("avepool back idle", {31'd0, busy}, 32'd0);
    check("b2b done_cnt", {16'd0, done_cnt}, 32'd3);

    // illegal op_type, plus clear colliding with a new illegal command
    issue(3'd3, 32'd9);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("illegal flags", {26'd0, err_illegal, cmd_ready, busy, done,
                            conv_ready | maxpool_ready, avepool_ready}, 32'b110000);
    @(negedge clk);
    check("illegal sticky", {31'd0, err_illegal}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("illegal cleared", {31'd0, err_illegal}, 32'd0);
    issue(3'd7, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    err_clr   = 1'b0;
    check("set beats clear", {31'd0, err_illegal}, 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("illegal cleared again", {31'd0, err_illegal}, 32'd0);
    check("illegal no count", {16'd0, done_cnt}, 32'd3);

    // op_num == 0 retires at once
    push_exp(3'b000, 3'd2, 32'd0, 1'b1);
    issue(3'd2, 32'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    check("zero-length done", {28'd0, done, cmd_ready, busy, conv_ready}, 32'b1100);
    check("zero-length done_cnt", {16'd0, done_cnt}, 32'd4);
    @(negedge clk);
    check("zero-length after", {30'd0, done, conv_ready}, 32'd0);

    // watchdog on the TIMEOUT=16 instance
    cmd_op_type = 3'd2;
    cmd_op_num  = 32'd9;
    cmd_valid_w = 1'b1;
    @(negedge clk);
    cmd_valid_w = 1'b0;
    @(negedge clk);
    cnt = 0;
    i = 0;
    any_done = 1'b0;
    while (w_conv_ready && (i < 40)) begin
      cnt++;
      if (w_done) any_done = 1'b1;
      @(negedge clk);
      i++;
    end
    check("timeout ready cycles", cnt, 32'd16);
    check("timeout flags", {29'd0, w_err_timeout, w_done, any_done}, 32'b100);
    check("timeout done_cnt", {16'd0, w_done_cnt}, 32'd0);
    @(negedge clk);
    check("timeout back idle", {30'd0, w_busy, w_cmd_ready}, 32'b01);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("timeout cleared", {31'd0, w_err_timeout}, 32'd0);

    // reset while avepool is running; stale valid afterwards must not retire anything
    push_exp(3'b100, 3'd5, 32'd7, 1'b0);
    issue(3'd5, 32'd7);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready(3'b100);
    @(negedge clk);
    rst = 1'b0;
    avepool_valid = 1'b1;
    @(negedge clk);
    check("mid-run reset flags", {24'd0, cmd_ready, busy, done, err_illegal, err_timeout,
                                  conv_ready, maxpool_ready, avepool_ready}, 32'd0);
    check("mid-run reset op", {29'd0, op_type} | op_num, 32'd0);
    check("mid-run reset done_cnt", {16'd0, done_cnt}, 32'd0);
    rst = 1'b1;
    exp_cnt = 16'd0;
    repeat (4) @(negedge clk);
    avepool_valid = 1'b0;
    @(negedge clk);
    check("post-reset idle", {29'd0, cmd_ready, busy, done_cnt == 16'd0}, 32'b101);

    // conv with a spurious maxpool_valid during RUN
    push_exp(3'b001, 3'd2, 32'd5, 1'b1);
    issue(3'd2, 32'd5);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_ready(3'b001);
    maxpool_valid = 1'b1;
    ok = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (!conv_ready || done || maxpool_ready) ok = 1'b0;
    end
    maxpool_valid = 1'b0;
    @(negedge clk);
    check("spurious valid ignored", {30'd0, ok, conv_ready}, 32'b11);
    conv_valid = 1'b1;
    @(negedge clk);
    check("conv after reset done", {30'd0, done, conv_ready}, 32'b10);
    check("conv after reset count", {16'd0, done_cnt}, 32'd1);
    conv_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("final idle", {31'd0, busy}, 32'd0);

    repeat (3) @(negedge clk);
    check("start queue drained", start_q.size(), 32'd0);
    check("done queue drained", done_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
